// File: rtl/ddr3_arb_pkg.sv
// Shared types and default widths for the two-requester DDR3 read arbiter.
// The optional performance counters are enabled with the DDR3_ARB_PERF_EN macro.
package ddr3_arb_pkg;

    // Requester identity carried with each issued read (0: block matching, 1: display)
    typedef logic [0:0] req_id_t;

    // Occupancy of the single address issue register
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } issue_state_t;

    localparam int ADDR_W_DEF = 29;
    localparam int DATA_W_DEF = 256;

endpackage

// File: rtl/ddr3_arb_tag_fifo.sv
// Requester-ID tag FIFO: remembers which requester each in-flight read belongs to,
// so returned beats can be routed in issue order. Push and pop may share a cycle.
module ddr3_arb_tag_fifo
    import ddr3_arb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push,
    input  req_id_t push_id,
    input  logic    pop,
    output req_id_t pop_id,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    req_id_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // The extra pointer MSB tells a full FIFO apart from an empty one
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign pop_id  = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset discards every stored tag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Tag storage, written on push only
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_id;
    end

endmodule

// File: rtl/ddr3_read_arbiter.sv
// Round-robin arbiter sharing one DDR3 read port between two requesters.
// Registered address issue stage, outstanding-read limit and in-order beat routing.
// Define DDR3_ARB_PERF_EN to add the perf_grants0/perf_grants1/perf_stall counters.
module ddr3_read_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MAX_OUT = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [ADDR_W-1:0]          req0_addr_data,
    input  logic                       req0_addr_valid,
    output logic                       req0_addr_ready,
    input  logic [ADDR_W-1:0]          req1_addr_data,
    input  logic                       req1_addr_valid,
    output logic                       req1_addr_ready,
    output logic [ADDR_W-1:0]          mem_addr_data,
    output logic                       mem_addr_valid,
    input  logic                       mem_addr_ready,
    input  logic [DATA_W-1:0]          mem_rdata_data,
    input  logic                       mem_rdata_valid,
    output logic [DATA_W-1:0]          rsp0_data,
    output logic                       rsp0_valid,
    output logic [DATA_W-1:0]          rsp1_data,
    output logic                       rsp1_valid,
    output logic [$clog2(MAX_OUT):0]   outstanding,
`ifdef DDR3_ARB_PERF_EN
    output logic [31:0]                perf_grants0,
    output logic [31:0]                perf_grants1,
    output logic [31:0]                perf_stall,
`endif
    output logic                       err_unexpected
);

    localparam int OW = $clog2(MAX_OUT) + 1;

    issue_state_t      state_q;
    issue_state_t      state_d;
    req_id_t           last_grant;
    req_id_t           grant;
    req_id_t           id_p0;
    req_id_t           pop_id;
    logic              held;
    logic              mem_hs;
    logic              room;
    logic              can_accept;
    logic              accept;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] rdata_p1;

    // Issue register and limit: the held address counts against the in-flight budget
    assign held           = (state_q == ST_FULL);
    assign mem_addr_valid = held & ~fifo_full;
    assign mem_hs         = mem_addr_valid & mem_addr_ready;
    assign room           = ({1'b0, outstanding} + (OW+1)'(held)) < (OW+1)'(MAX_OUT);
    assign can_accept     = reset_n & (~held | mem_hs) & room;
    assign pop            = mem_rdata_valid & ~fifo_empty;

    // Round-robin grant: a lone requester wins, otherwise the one not served last
    always_comb begin
        grant = ~last_grant;
        if (req0_addr_valid && !req1_addr_valid) grant = 1'b0;
        else if (req1_addr_valid && !req0_addr_valid) grant = 1'b1;
    end

    assign req0_addr_ready = can_accept & (grant == 1'b0);
    assign req1_addr_ready = can_accept & (grant == 1'b1);
    assign accept          = (req0_addr_ready & req0_addr_valid) | (req1_addr_ready & req1_addr_valid);

    // Issue register next state: a new accept refills it, a bare handshake drains it
    always_comb begin
        state_d = state_q;
        if (accept) state_d = ST_FULL;
        else if (mem_hs) state_d = ST_EMPTY;
    end

    // Issue-stage control: occupancy and the round-robin pointer
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            last_grant <= 1'b1;
        end else begin
            state_q <= state_d;
            if (accept) last_grant <= grant;
        end
    end

    // ---- stage p0: address and requester tag captured on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_addr_data <= grant ? req1_addr_data : req0_addr_data;
            id_p0         <= grant;
        end
    end

    ddr3_arb_tag_fifo #(
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (mem_hs),
        .push_id (id_p0),
        .pop     (pop),
        .pop_id  (pop_id),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // In-flight count follows pushes and pops; a simultaneous pair cancels
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else begin
            case ({mem_hs, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // ---- stage p1: response valids routed by tag, sticky error for untagged beats
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp0_valid     <= 1'b0;
            rsp1_valid     <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            rsp0_valid     <= pop & (pop_id == 1'b0);
            rsp1_valid     <= pop & (pop_id == 1'b1);
            err_unexpected <= err_unexpected | (mem_rdata_valid & fifo_empty);
        end
    end

    // ---- stage p1: returned beat data, shared by both response ports
    always_ff @(posedge clk) begin
        rdata_p1 <= mem_rdata_data;
    end

    assign rsp0_data = rdata_p1;
    assign rsp1_data = rdata_p1;

`ifdef DDR3_ARB_PERF_EN
    // Handshake counts per requester and cycles where a request waited unserved
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_grants0 <= '0;
            perf_grants1 <= '0;
            perf_stall   <= '0;
        end else begin
            if (mem_hs && id_p0 == 1'b0) perf_grants0 <= perf_grants0 + 1'b1;
            if (mem_hs && id_p0 == 1'b1) perf_grants1 <= perf_grants1 + 1'b1;
            if ((req0_addr_valid | req1_addr_valid) && !(req0_addr_ready | req1_addr_ready))
                perf_stall <= perf_stall + 1'b1;
        end
    end
`endif

endmodule
